rr_sel_gen: RTL and testbench
=============================

// Module: rr_sel_gen
//
// PURPOSE
//   Round-robin request selector that feeds the 4-to-16 line decoder stage.
//   - Samples 16 request lines and picks one owner at a time, fairly.
//   - Presents the owner as a registered 4-bit index code[3:0] plus enable en;
//     these wire straight into the decoder's ip[3:0]/en inputs.
//   - Holds each grant until the owner signals done, withdraws its request,
//     or a hold timeout expires.
//
// PARAMETERS
//   TIMEOUT  64  max cycles en stays high for one grant; 0 disables timeout
//   CW       8   hold-counter width; TIMEOUT <= 2**CW - 1 required
//
// PORTS
//   clk    in   1   rising-edge clock
//   rst_n  in   1   reset, asynchronous, active-low
//   req    in   16  request lines, bit i = requester i, level-sensitive
//   done   in   1   owner finished; sampled only while en=1
//   code   out  4   granted index, registered; to decoder ip[3:0]
//   en     out  1   grant active, registered; to decoder en
//   tmo    out  1   one-cycle pulse: grant released by timeout
//
// BEHAVIOUR
//   Reset (async, rst_n=0): code=0, en=0, tmo=0, ptr=0, cnt=0, state=IDLE.
//     - Applies immediately, including mid-grant: en drops without waiting for clk.
//   State registers: ptr[3:0] (search start), cnt[CW-1:0], state {IDLE,GRANT}.
//   IDLE (en=0):
//     - If req != 0, pick the first set bit searching ptr, ptr+1, ..., ptr+15
//       (mod 16).
//     - Next edge: code=idx, en=1, cnt=0, state=GRANT.
//     - Latency: req sampled high -> en high 1 cycle later.
//     - If req == 0: hold; code keeps its last value; en=0.
//   GRANT (en=1, code stable for the whole grant):
//     - Release conditions, priority order:
//       (a) done=1
//       (b) req[code]=0 (withdrawn)
//       (c) TIMEOUT!=0 and cnt==TIMEOUT-1
//     - On release, next edge: en=0, ptr=code+1 (15 wraps to 0), state=IDLE.
//       tmo=1 for that one cycle only if (c) fired and neither (a) nor (b) did.
//     - Otherwise: cnt=cnt+1.
//     - Timeout => en is high exactly TIMEOUT cycles.
//   Fairness / timing:
//     - en is low exactly 1 cycle between back-to-back grants.
//     - The just-served index has lowest priority on the next search.
//   done while en=0: ignored.
//   Requests that change during GRANT (other than req[code]): no effect until
//     the next IDLE search.
//   Outputs are registered only; no combinational path from req/done to code/en.
//   Sole requester: re-granted after the 1-cycle gap (ptr wraps to it).
//
// TESTING
//   1. rst_n=0 with req=16'hFFFF -> en=0, code=0, tmo=0.
//      Release reset -> en=1, code=0 one cycle later.
//   2. req=16'h8001 held, done pulsed in each grant -> code sequence 0,15,0,15;
//      en low exactly 1 cycle between grants.
//   3. Wrap: req=16'h4003, done each grant -> codes 0,1,14,0,1,14.
//   4. Withdraw: grant code=5, drop req[5] -> en=0 next cycle, tmo=0.
//      With req[6] set, next code=6.
//   5. TIMEOUT=4, req=16'h0008 held, no done -> en high exactly 4 cycles;
//      tmo=1 on the cycle en falls; re-grant code=3 after a 1-cycle gap.
//   6. TIMEOUT=4: done=1 on 4th grant cycle -> release, tmo=0.
//      Assert rst_n=0 mid-grant -> en=0 immediately; restart grants from index 0.

Source files
------------

// File: rtl/rr_sel_gen.sv
// Round-robin selector over 16 request lines. It drives a registered 4-bit owner
// index plus an enable into the downstream 4-to-16 decoder.
module rr_sel_gen #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  code,
  output logic        en,
  output logic        tmo
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [3:0]    ptr, ptr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    code_next;
  logic          en_next, tmo_next;

  logic [31:0]   req_dbl;
  logic [15:0]   req_rot;
  logic [3:0]    offset;
  logic          rel_done, rel_wd, rel_to;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit is the next owner.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[15:0];
    offset  = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) offset = 4'(i);
    end
  end

  always_comb begin
    rel_done = done;
    rel_wd   = !req[code];
    rel_to   = (TIMEOUT != 0) && (cnt == TMO_LAST);
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    code_next  = code;
    en_next    = en;
    tmo_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req != 16'h0) begin
          code_next  = ptr + offset;
          en_next    = 1'b1;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_wd || rel_to) begin
          en_next    = 1'b0;
          ptr_next   = code + 4'd1;
          state_next = IDLE;
          tmo_next   = !rel_done && !rel_wd;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      code  <= '0;
      en    <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      code  <= code_next;
      en    <= en_next;
      tmo   <= tmo_next;
    end
  end

endmodule

// File: tb/tb_rr_sel_gen.sv
// Directed and randomized checks of rr_sel_gen against a grant-level reference model
// (owner search from ptr, hold age, release reasons).
module tb_rr_sel_gen;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  code;
  logic        en;
  logic        tmo;

  int tests = 0;
  int fails = 0;

  // Reference model state: next search start, current owner, cycles held so far.
  int m_ptr, m_code, m_held;
  bit m_en, m_tmo;

  rr_sel_gen #(.TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .code(code), .en(en), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_code = 0; m_held = 0; m_en = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit found, by_done, by_wd, by_to;
    if (!m_en) begin
      m_tmo = 0;
      if (req != 16'h0) begin
        found = 0;
        for (int k = 0; k < 16; k++) begin
          if (!found && req[(m_ptr + k) % 16]) begin
            m_code = (m_ptr + k) % 16;
            found  = 1;
          end
        end
        m_en   = 1;
        m_held = 1;
      end
    end else begin
      by_done = done;
      by_wd   = !req[m_code];
      by_to   = (TO != 0) && (m_held == TO);
      if (by_done || by_wd || by_to) begin
        m_en  = 0;
        m_ptr = (m_code + 1) % 16;
        m_tmo = !by_done && !by_wd;
      end else begin
        m_held++;
        m_tmo = 0;
      end
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model_en", en, m_en);
    check("model_code", code, m_code);
    check("model_tmo", tmo, m_tmo);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_en", en, 0);
    check("rst_code", code, 0);
    check("rst_tmo", tmo, 0);
    rst_n = 1'b1;
  endtask

  task automatic serve(output logic [3:0] c);
    cycle();
    check("serve_en", en, 1);
    c = code;
    done = 1'b1;
    cycle();
    check("serve_gap", en, 0);
    done = 1'b0;
  endtask

  logic [3:0] got;
  logic [3:0] seq2 [4];
  logic [3:0] seq3 [6];
  int n;

  initial begin
    seq2 = '{4'd0, 4'd15, 4'd0, 4'd15};
    seq3 = '{4'd0, 4'd1, 4'd14, 4'd0, 4'd1, 4'd14};
    @(posedge clk); #1;

    // 1: reset with all requests pending, first grant one cycle after release
    req = 16'hFFFF;
    reset_dut();
    cycle();
    check("t1_en", en, 1);
    check("t1_code", code, 0);

    // 2: two requesters alternate
    reset_dut();
    req = 16'h8001;
    for (int g = 0; g < 4; g++) begin
      serve(got);
      check("t2_seq", got, seq2[g]);
    end

    // 3: three requesters with wrap
    reset_dut();
    req = 16'h4003;
    for (int g = 0; g < 6; g++) begin
      serve(got);
      check("t3_seq", got, seq3[g]);
    end

    // 4: owner withdraws its request
    reset_dut();
    req = 16'h0060;
    cycle();
    check("t4_code5", code, 5);
    req = 16'h0040;
    cycle();
    check("t4_drop_en", en, 0);
    check("t4_drop_tmo", tmo, 0);
    cycle();
    check("t4_code6", code, 6);

    // 5: timeout with a sole requester
    reset_dut();
    req = 16'h0008;
    cycle();
    check("t5_code", code, 3);
    n = 1;
    while (en && n < 10) begin
      cycle();
      if (en) n++;
    end
    check("t5_high_cycles", n, TO);
    check("t5_tmo", tmo, 1);
    cycle();
    check("t5_regrant_en", en, 1);
    check("t5_regrant_code", code, 3);
    check("t5_tmo_clear", tmo, 0);

    // 6: done on the last allowed cycle wins over timeout; then async reset mid-grant
    repeat (3) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("t6_rel_en", en, 0);
    check("t6_rel_tmo", tmo, 0);
    cycle();
    check("t6_regrant", en, 1);
    req = 16'hFFFF;
    reset_dut();
    cycle();
    check("t6_restart_code", code, 0);
    check("t6_restart_en", en, 1);

    // Randomized traffic: requests change occasionally, done is sparse
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = 16'($urandom & $urandom);
      done = ($urandom_range(5) == 0);
      cycle();
    end
    done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
